// File: rtl/split_fifo_param_if.sv
// Ready/valid stream bundle for split_fifo_param.
// Upstream: valid0/data_in/ready0. Downstream: valid1/data_out/ready1.
interface split_fifo_param_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  valid0;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  ready0;
   logic                  valid1;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ready1;

   modport master (
      output valid0, data_in, ready1,
      input  ready0, valid1, data_out
   );

   modport slave (
      input  valid0, data_in, ready1,
      output ready0, valid1, data_out
   );
endinterface

// File: rtl/split_fifo_param.sv
// Parametrised ready/valid split FIFO with register mode and flush.
// Define SPLIT_FIFO_BYPASS_EN for zero-latency fall-through when empty.
module split_fifo_param #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_en,
   input  logic             fifo_en,
   input  logic             flush,
   input  logic             start_fifo,
   input  logic             end_fifo,
   split_fifo_param_if.slave s,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [CNT_W-1:0]      r_count;

   logic                  w_ready_in;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_store;
   logic                  w_pop_st;
   logic [DATA_WIDTH-1:0] w_rd_data;

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign w_ready_in = s.ready1 & ~start_fifo;
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == FULL_CNT);
   assign w_rd_data  = r_mem[r_rd_ptr];

   assign s.ready0 = fifo_en ? (~w_full | w_ready_in) : clk_en;

`ifdef SPLIT_FIFO_BYPASS_EN
   logic w_valid_in;
   assign w_valid_in = s.valid0 & ~end_fifo;
   assign s.valid1   = fifo_en ? (~w_empty | w_valid_in) : clk_en;
   assign s.data_out = !fifo_en ? r_mem[0] :
                       w_empty  ? s.data_in : w_rd_data;
   // Empty push+pop falls straight through and is never written
   assign w_store    = w_push & ~(w_empty & w_pop);
`else
   assign s.valid1   = fifo_en ? ~w_empty : clk_en;
   assign s.data_out = fifo_en ? w_rd_data : r_mem[0];
   assign w_store    = w_push;
`endif

   assign w_push   = clk_en & s.valid0 & s.ready0;
   assign w_pop    = clk_en & s.valid1 & s.ready1;
   assign w_pop_st = w_pop & ~w_empty;

   assign count = fifo_en ? r_count : '0;
   assign empty = ~fifo_en | w_empty;
   assign full  = fifo_en & w_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (clk_en) begin
         if (!fifo_en) begin
            r_mem[0] <= s.data_in;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
         end else begin
            // When full, wr_ptr == rd_ptr: the old word is read out before
            // the new one lands in the same slot at this edge
            if (w_store) begin
               r_mem[r_wr_ptr] <= s.data_in;
               r_wr_ptr        <= nxt(r_wr_ptr);
            end
            if (w_pop_st) begin
               r_rd_ptr <= nxt(r_rd_ptr);
            end
            if (w_store && !w_pop_st) begin
               r_count <= r_count + 1'b1;
            end else if (!w_store && w_pop_st) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end
endmodule
